// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader.
package uart_loader_pkg;
  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR
  } state_t;

  localparam logic [7:0] MAGIC = 8'hA5;
endpackage

// File: rtl/toggle_pulse.sv
// Converts a toggle-per-event strobe into a registered one-cycle pulse.
// The first cycle out of reset only captures the input level, so a strobe
// that is already high at reset release is not mistaken for an event.
module toggle_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic tog_in,
  output logic pulse
);
  logic armed_q, armed_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    armed_d = 1'b1;
    prev_d  = tog_in;
    pulse_d = armed_q & (tog_in ^ prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;
endmodule

// File: rtl/uart_boot_loader.sv
// Parses a framed program image from the UART receiver, writes it to
// instruction memory and releases the CPU reset once the checksum matches.
module uart_boot_loader
  import uart_loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 4096,
  parameter int                TIMEOUT   = 2621440
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_update,
  input  logic [7:0]        rx_byte,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int GAP_W = $clog2(TIMEOUT + 1);

  logic        ev;
  logic [7:0]  byte_q, byte_d;
  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  k_q, k_d;
  logic [7:0]  chk_q, chk_d;
  logic        err_q, err_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [7:0]  chk_nx;
  logic [15:0] len_nx;
  logic        counting;

  toggle_pulse u_tog (
    .clk   (clk),
    .rst_n (rst_n),
    .tog_in(rx_update),
    .pulse (ev)
  );

  // Byte is captured alongside the edge detect so both reach the parser together.
  assign byte_d = rx_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_q    <= '0;
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      word_q    <= '0;
      k_q       <= '0;
      chk_q     <= '0;
      err_q     <= 1'b0;
      cpu_rst_q <= 1'b0;
      gap_q     <= '0;
    end else begin
      byte_q    <= byte_d;
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      k_q       <= k_d;
      chk_q     <= chk_d;
      err_q     <= err_d;
      cpu_rst_q <= cpu_rst_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    word_d    = word_q;
    k_d       = k_q;
    chk_d     = chk_q;
    err_d     = err_q;
    cpu_rst_d = (state_q == DONE);
    chk_nx    = chk_q ^ byte_q;
    len_nx    = {byte_q, len_q[7:0]};
    counting  = state_q inside {LEN_LO, LEN_HI, DATA, CHECK};

    // Inter-byte gap: frozen while a write is pending, idle outside a frame.
    if (ev)                    gap_d = '0;
    else if (counting)         gap_d = gap_q + GAP_W'(1);
    else if (state_q == WRITE) gap_d = gap_q;
    else                       gap_d = '0;

    unique case (state_q)
      IDLE: if (ev && byte_q == MAGIC) begin
        state_d = LEN_LO;
        err_d   = 1'b0;
        chk_d   = '0;
        idx_d   = '0;
      end
      LEN_LO: if (ev) begin
        len_d[7:0] = byte_q;
        chk_d      = chk_nx;
        state_d    = LEN_HI;
      end
      LEN_HI: if (ev) begin
        len_d   = len_nx;
        chk_d   = chk_nx;
        k_d     = '0;
        state_d = (len_nx == '0 || {16'h0, len_nx} > 32'(MAX_WORDS)) ? ERROR : DATA;
      end
      DATA: if (ev) begin
        word_d[8*k_q +: 8] = byte_q;
        chk_d = chk_nx;
        k_d   = k_q + 2'd1;
        if (k_q == 2'd3) state_d = WRITE;
      end
      // A byte landing while the write is pending is an overrun and beats mem_ready.
      WRITE: begin
        if (ev) state_d = ERROR;
        else if (mem_ready) begin
          idx_d   = idx_q + 16'd1;
          state_d = (idx_q == len_q - 16'd1) ? CHECK : DATA;
        end
      end
      CHECK: if (ev) begin
        chk_d   = chk_nx;
        state_d = (chk_nx == '0) ? DONE : ERROR;
      end
      DONE:  ;
      ERROR: state_d = IDLE;
    endcase

    if (counting && !ev && gap_q >= GAP_W'(TIMEOUT)) state_d = ERROR;
    if (state_d == ERROR) err_d = 1'b1;
  end

  always_comb begin
    mem_we    = (state_q == WRITE) && !ev;
    mem_addr  = BASE_ADDR + (ADDR_W'(idx_q) << 2);
    mem_wdata = word_q;
    busy      = !(state_q inside {IDLE, DONE});
    done      = (state_q == DONE);
    error     = err_q;
    cpu_rst_n = cpu_rst_q;
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized scoreboard bench for uart_boot_loader with a frame-level reference model.
module tb_uart_boot_loader;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_4000;
  localparam int          MAXW   = 4096;
  localparam int          TMO    = 400;
  localparam int          BGAP   = 12;

  logic        clk = 1'b0, rst_n = 1'b0, rx_update = 1'b0, mem_ready = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        mem_we, cpu_rst_n, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_q[$];
  logic [31:0] wq[$];
  int  n_chk = 0, n_pass = 0;
  bit  stall_mode = 1'b0;
  int  wait_cnt = 0;

  always #5 clk = ~clk;

  uart_boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_update(rx_update), .rx_byte(rx_byte),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // Memory side: random backpressure, never more than 3 stall cycles unless stalling on purpose.
  initial forever begin
    @(posedge clk); #1;
    if (stall_mode)         mem_ready = 1'b0;
    else if (wait_cnt >= 3) mem_ready = 1'b1;
    else                    mem_ready = 1'($urandom_range(0, 1));
    wait_cnt = (mem_we && !mem_ready) ? wait_cnt + 1 : 0;
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (rst_n && mem_we && mem_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  // CPU reset must stay low on the first DONE cycle and rise on the next.
  initial begin
    bit d1, d2;
    d1 = 0; d2 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin d1 = 0; d2 = 0; end
      else begin
        if (done && !d1)       check("cpu_rst_n_entry", 64'(cpu_rst_n), 64'd0);
        if (done && d1 && !d2) check("cpu_rst_n_after", 64'(cpu_rst_n), 64'd1);
        d2 = d1; d1 = done;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte = b;
    rx_update = ~rx_update;
    repeat (BGAP - 1) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    stall_mode = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // Reference model: builds the frame from wq, queues the writes it implies and
  // predicts whether the load completes.
  task automatic run_frame(input logic [15:0] len, input logic [7:0] chk_flip, output bit exp_done);
    logic [7:0] bytes[$];
    logic [7:0] chk;
    bit valid;
    chk   = len[7:0] ^ len[15:8];
    valid = (len != 0) && (int'(len) <= MAXW);
    bytes.push_back(8'hA5);
    bytes.push_back(len[7:0]);
    bytes.push_back(len[15:8]);
    exp_done = 1'b0;
    if (valid) begin
      for (int i = 0; i < wq.size(); i++) begin
        logic [31:0] w;
        w = wq[i];
        for (int b = 0; b < 4; b++) begin
          bytes.push_back(w[8*b +: 8]);
          chk ^= w[8*b +: 8];
        end
        exp_q.push_back('{addr: BASE + 32'(4 * i), data: w});
      end
      bytes.push_back(chk ^ chk_flip);
      exp_done = (chk_flip == 8'h00);
    end
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic check_outcome(input bit exp_done);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("done", 64'(done), 64'(exp_done));
    check("error", 64'(error), 64'(!exp_done));
    check("cpu_rst_n", 64'(cpu_rst_n), 64'(exp_done));
    check("busy_after", 64'(busy), 64'd0);
    check("writes_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    bit ed;
    // Reset with the strobe already high and the magic byte on the bus.
    rx_update = 1'b1;
    rx_byte   = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("arm_no_event_busy", 64'(busy), 64'd0);
    check("arm_cpu_rst_n", 64'(cpu_rst_n), 64'd0);

    // Directed good frame, then bytes after DONE are ignored.
    wq = '{32'h12345678, 32'hDEADBEEF};
    run_frame(16'd2, 8'h00, ed);
    check_outcome(ed);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    @(negedge clk);
    check("done_terminal", 64'(done), 64'd1);
    check("done_not_busy", 64'(busy), 64'd0);

    // Bad checksum writes both words then errors; a good resend completes.
    do_reset();
    run_frame(16'd2, 8'h01, ed);
    check_outcome(ed);
    run_frame(16'd2, 8'h00, ed);
    check_outcome(ed);

    // Junk before magic, zero length, oversize length.
    do_reset();
    send_byte(8'h00); send_byte(8'hFF);
    @(negedge clk);
    check("junk_ignored", 64'(busy), 64'd0);
    wq = {};
    run_frame(16'd0, 8'h00, ed);
    check_outcome(ed);
    run_frame(16'h1001, 8'h00, ed);
    check_outcome(ed);

    // Stalled write overrun by the next byte.
    stall_mode = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("stall_mem_we", 64'(mem_we), 64'd1);
    check("stall_addr", 64'(mem_addr), 64'(BASE));
    check("stall_data", 64'(mem_wdata), 64'h11223344);
    @(posedge clk); #1;
    rx_byte = 8'h00; rx_update = ~rx_update;
    @(posedge clk); @(negedge clk);
    check("overrun_we_drop", 64'(mem_we), 64'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("overrun_error", 64'(error), 64'd1);
    check("overrun_done", 64'(done), 64'd0);
    stall_mode = 1'b0;

    // Inter-byte timeout mid-word.
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    repeat (TMO - 40) @(posedge clk);
    @(negedge clk);
    check("pre_timeout_busy", 64'(busy), 64'd1);
    check("pre_timeout_error", 64'(error), 64'd0);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("timeout_error", 64'(error), 64'd1);
    check("timeout_idle", 64'(busy), 64'd0);

    // Reset asserted mid-DATA.
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h11);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_we", 64'(mem_we), 64'd0);
    check("midrst_error", 64'(error), 64'd0);
    check("midrst_cpu", 64'(cpu_rst_n), 64'd0);
    do_reset();
    wq = '{32'hCAFEF00D};
    run_frame(16'd1, 8'h00, ed);
    check_outcome(ed);

    // Randomized frames.
    for (int it = 0; it < 10; it++) begin
      int r;
      logic [15:0] len;
      logic [7:0]  flip;
      do_reset();
      r = int'($urandom_range(0, 7));
      wq = {};
      if (r == 0)      len = 16'd0;
      else if (r == 1) len = 16'(MAXW + 1 + int'($urandom_range(0, 100)));
      else begin
        len = 16'($urandom_range(1, 5));
        for (int i = 0; i < int'(len); i++) wq.push_back($urandom());
      end
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(len, flip, ed);
      check_outcome(ed);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
